// File: rtl/path_replayer.sv
// path_replayer: captures a solved maze path from the solver and replays it over valid/ready
// Ports:
//   clk, rst         clock and asynchronous active-low reset
//   Start            restart pulse shared with the solver; returns this block to IDLE
//   Done, Fail       solver outcome levels
//   Move, The_End    cell delivered one cycle after Run ([7:4] row, [3:0] col), last-cell flag
//   Run              one-cycle request for the next cell
//   step_data/valid  replayed cell and its valid, accepted by step_ready
//   path_len         cells captured; path_err non-adjacent step or overflow (sticky)
//   no_path          solver failed; replay_done one-cycle pulse after the last accept
//   busy             high outside IDLE, NOPATH and ERR
module path_replayer #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Start,
    input  logic          Done,
    input  logic          Fail,
    input  logic [7:0]    Move,
    input  logic          The_End,
    output logic          Run,
    output logic [7:0]    step_data,
    output logic          step_valid,
    input  logic          step_ready,
    output logic [AW:0]   path_len,
    output logic          path_err,
    output logic          no_path,
    output logic          replay_done,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, REPLAY, FINISH, NOPATH, ERR} state_e;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [7:0]    prev_q, prev_d, data_q, data_d;
    logic          err_q, err_d, nop_q, nop_d, seen_q, seen_d;
    logic          wr_en, adj, last;
    logic [AW:0]   len_inc;
    logic [AW-1:0] rd_nx;
    logic [4:0]    r, c, pr, pc;
    logic [7:0]    mem [DEPTH];

    // Coordinates widened by one bit so 15 -> 0 never looks like a unit step
    assign r       = {1'b0, Move[7:4]};
    assign c       = {1'b0, Move[3:0]};
    assign pr      = {1'b0, prev_q[7:4]};
    assign pc      = {1'b0, prev_q[3:0]};
    assign adj     = (r == pr && (c == pc + 5'd1 || pc == c + 5'd1)) ||
                     (c == pc && (r == pr + 5'd1 || pr == r + 5'd1));
    assign len_inc = len_q + 1'b1;
    assign rd_nx   = rd_q + 1'b1;
    assign last    = {1'b0, rd_q} == len_q - 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rd_d    = rd_q;
        prev_d  = prev_q;
        data_d  = data_q;
        err_d   = err_q;
        nop_d   = nop_q;
        seen_d  = seen_q;
        wr_en   = 1'b0;
        if (Start) begin
            state_d = IDLE;
            len_d   = '0;
            rd_d    = '0;
            err_d   = 1'b0;
            nop_d   = 1'b0;
            seen_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // seen_q stops a second capture while Done is still held after FINISH
                    if (Done && !seen_q) begin
                        state_d = REQ;
                        seen_d  = 1'b1;
                    end else if (Fail) begin
                        state_d = NOPATH;
                        nop_d   = 1'b1;
                        seen_d  = 1'b1;
                    end
                end
                REQ: state_d = WAIT;
                WAIT: begin
                    wr_en  = 1'b1;
                    len_d  = len_inc;
                    prev_d = Move;
                    if (len_q != '0 && !adj)
                        err_d = 1'b1;
                    if (The_End) begin
                        state_d = REPLAY;
                        rd_d    = '0;
                        // buf[0] is only being written now for a one-cell path, so bypass it
                        data_d  = (len_q == '0) ? Move : mem[0];
                    end else if (len_inc == FULL) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
                REPLAY: begin
                    if (step_ready) begin
                        rd_d   = rd_nx;
                        data_d = mem[rd_nx];
                        if (last)
                            state_d = FINISH;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            rd_q    <= '0;
            prev_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            nop_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            err_q   <= err_d;
            nop_q   <= nop_d;
            seen_q  <= seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[len_q[AW-1:0]] <= Move;
    end

    assign Run         = state_q == REQ;
    assign step_valid  = state_q == REPLAY;
    assign step_data   = data_q;
    assign replay_done = state_q == FINISH;
    assign busy        = !(state_q == IDLE || state_q == NOPATH || state_q == ERR);
    assign path_len    = len_q;
    assign path_err    = err_q;
    assign no_path     = nop_q;
endmodule

// File: tb/tb_path_replayer.sv
// tb_path_replayer: random and directed scoreboard bench for path_replayer
module tb_path_replayer;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 0, rst = 0, Start = 0, Done = 0, Fail = 0, The_End = 0, step_ready = 1;
    logic [7:0]    Move = 0;
    logic          Run, step_valid, path_err, no_path, replay_done, busy;
    logic [7:0]    step_data;
    logic [AW:0]   path_len;

    path_replayer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Done(Done), .Fail(Fail), .Move(Move),
        .The_End(The_End), .Run(Run), .step_data(step_data), .step_valid(step_valid),
        .step_ready(step_ready), .path_len(path_len), .path_err(path_err), .no_path(no_path),
        .replay_done(replay_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Solver model: answers each Run with the next cell of sol_q during the following cycle
    logic [7:0] sol_q[$];
    int         sol_idx = 0;
    bit         sol_end = 0;

    always @(negedge clk) begin
        if (rst && Run) begin
            Move    = (sol_idx < sol_q.size()) ? sol_q[sol_idx] : 8'hff;
            The_End = sol_end && (sol_idx == sol_q.size() - 1);
            sol_idx++;
        end
    end

    // Scoreboard monitor
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         runs = 0, last_run_cyc = 0, accs = 0, first_acc = 0, last_acc = 0;
    int         dones = 0, len_at_done = 0, err_at_done = 0;
    bit         prev_stall = 0, exp_done = 0;
    logic [7:0] prev_data = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            if (Run) begin
                if (runs > 0)
                    check("run_gap", 32'(cyc - last_run_cyc), 32'd2);
                runs++;
                last_run_cyc = cyc;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(step_valid), 32'd1);
                check("hold_data", 32'(step_data), 32'(prev_data));
            end
            if (replay_done || exp_done) begin
                check("replay_done", 32'(replay_done), 32'(exp_done));
                if (replay_done) begin
                    dones++;
                    len_at_done = int'(path_len);
                    err_at_done = int'(path_err);
                end
            end
            exp_done = 0;
            if (step_valid && step_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_step: got %0h expected none", step_data);
                end else begin
                    check("step_data", 32'(step_data), 32'(exp_q.pop_front()));
                    exp_done = exp_q.size() == 0;
                end
                accs++;
                if (accs == 1)
                    first_acc = cyc;
                last_acc = cyc;
            end
            prev_stall = step_valid && !step_ready && !Start;
            prev_data  = step_data;
        end else begin
            prev_stall = 0;
            exp_done   = 0;
        end
    end

    // Consumer: 0 always ready, 1 random, 2 three-cycle stall on the second entry, 3 stop after two
    int rmode = 0, stall_cnt = 0;

    always @(posedge clk) begin
        #1;
        case (rmode)
            1:       step_ready = ($urandom % 3) != 0;
            2: begin
                if (step_valid && accs == 1 && stall_cnt < 3) begin
                    step_ready = 0;
                    stall_cnt++;
                end else begin
                    step_ready = 1;
                end
            end
            3:       step_ready = accs < 2;
            default: step_ready = 1;
        endcase
    end

    function automatic bit adjacent(input logic [7:0] a, input logic [7:0] b);
        int ra = int'(a[7:4]), ca = int'(a[3:0]), rb = int'(b[7:4]), cb = int'(b[3:0]);
        return (ra == rb && (ca - cb == 1 || cb - ca == 1)) ||
               (ca == cb && (ra - rb == 1 || rb - ra == 1));
    endfunction

    task automatic pulse_start();
        Start = 1;
        Done  = 0;
        Fail  = 0;
        tick();
        Start = 0;
    endtask

    task automatic prep(input int mode);
        pulse_start();
        rmode     = mode;
        stall_cnt = 0;
        runs      = 0;
        accs      = 0;
        dones     = 0;
        sol_idx   = 0;
    endtask

    logic [7:0] cur_path[$];

    // Reference: capture stops at The_End or when DEPTH cells are stored without it
    task automatic run_path(input bit has_end, input int mode, input string tag);
        int n      = cur_path.size();
        bit ovf    = !(has_end && n <= DEPTH);
        int stored = ovf ? DEPTH : n;
        bit eerr   = ovf;
        int t      = 0;
        for (int i = 1; i < stored; i++)
            if (!adjacent(cur_path[i-1], cur_path[i]))
                eerr = 1;
        prep(mode);
        sol_q   = cur_path;
        sol_end = has_end;
        if (!ovf)
            foreach (cur_path[i]) exp_q.push_back(cur_path[i]);
        Done = 1;
        tick(2);
        while (busy && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still %0d expected 0", tag, busy);
        end
        check({tag, "_runs"}, 32'(runs), 32'(stored));
        check({tag, "_dones"}, 32'(dones), ovf ? 32'd0 : 32'd1);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        if (ovf) begin
            check({tag, "_len"}, 32'(path_len), 32'(DEPTH));
            check({tag, "_err"}, 32'(path_err), 32'd1);
            check({tag, "_valid"}, 32'(step_valid), 32'd0);
        end else begin
            check({tag, "_len"}, 32'(len_at_done), 32'(n));
            check({tag, "_err"}, 32'(err_at_done), 32'(eerr));
        end
        exp_q.delete();
    endtask

    initial begin
        int t;
        #2;
        check("rst_run", 32'(Run), 32'd0);
        check("rst_valid", 32'(step_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_len", 32'(path_len), 32'd0);
        check("rst_data", 32'(step_data), 32'd0);
        check("rst_flags", {29'd0, path_err, no_path, replay_done}, 32'd0);
        @(negedge clk);
        rst = 1;
        tick(2);

        cur_path = {8'h00, 8'h01, 8'h02, 8'h12};
        run_path(1, 0, "straight");
        check("straight_consec", 32'(last_acc - first_acc), 32'd3);

        run_path(1, 2, "backpressure");
        check("bp_stalls", 32'(stall_cnt), 32'd3);

        cur_path = {8'h00, 8'h11, 8'h12};
        run_path(1, 0, "diag");

        cur_path = {8'h0f, 8'h00};
        run_path(1, 0, "nowrap");

        prep(0);
        Fail = 1;
        tick(6);
        check("fail_no_path", 32'(no_path), 32'd1);
        check("fail_busy", 32'(busy), 32'd0);
        check("fail_runs", 32'(runs), 32'd0);
        pulse_start();
        check("fail_clear", 32'(no_path), 32'd0);
        check("fail_idle_busy", 32'(busy), 32'd0);

        cur_path = {8'h00, 8'h01, 8'h02, 8'h03, 8'h13};
        run_path(0, 0, "overflow");

        cur_path = {8'h20, 8'h21, 8'h31, 8'h41};
        run_path(1, 1, "exactfill");

        prep(3);
        sol_q   = cur_path;
        sol_end = 1;
        foreach (cur_path[i]) exp_q.push_back(cur_path[i]);
        Done = 1;
        t = 0;
        while (accs < 2 && t < 200) begin
            tick();
            t++;
        end
        check("mid_accs", 32'(accs), 32'd2);
        Start = 1;
        Done  = 0;
        tick();
        Start = 0;
        check("mid_valid", 32'(step_valid), 32'd0);
        check("mid_len", 32'(path_len), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        tick(3);

        prep(0);
        sol_q   = cur_path;
        sol_end = 1;
        Done    = 1;
        t = 0;
        while (runs < 2 && t < 200) begin
            tick();
            t++;
        end
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        check("arst_run", 32'(Run), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_len", 32'(path_len), 32'd0);
        check("arst_valid", 32'(step_valid), 32'd0);
        check("arst_flags", {29'd0, path_err, no_path, replay_done}, 32'd0);
        Done = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1;
        tick(2);

        for (int k = 0; k < 16; k++) begin
            int n   = (k % 4 == 3) ? DEPTH + 1 : 1 + int'($urandom_range(DEPTH - 1));
            int row = int'($urandom_range(15));
            int col = int'($urandom_range(15));
            cur_path = {};
            for (int i = 0; i < n; i++) begin
                int d = int'($urandom_range(3));
                int nr = row + (d == 0 ? 1 : d == 1 ? -1 : 0);
                int nc = col + (d == 2 ? 1 : d == 3 ? -1 : 0);
                if (i > 0) begin
                    if (nr < 0 || nr > 15 || nc < 0 || nc > 15 || $urandom_range(5) == 0) begin
                        nr = int'($urandom_range(15));
                        nc = int'($urandom_range(15));
                    end
                    row = nr;
                    col = nc;
                end
                cur_path.push_back({4'(row), 4'(col)});
            end
            run_path(k % 4 != 3, 1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
